// File: rtl/swd_target_responder.sv
// SWD target-side wire responder. SWCLK and SWDIO are oversampled in the clk
// domain. The block decodes request packets, returns ACK and read data, and
// captures write data. All line activity is tied to the detected SWCLK rising
// edge, so the probe samples target data on SWCLK falling edges.
module swd_target_responder #(
  parameter int unsigned LINE_RESET_BITS = 50,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swclk_i,
  input  logic        swdio_i,
  output logic        swdio_o,
  output logic        swdio_t,
  output logic        req_valid,
  output logic        req_apndp,
  output logic        req_rnw,
  output logic [1:0]  req_addr,
  input  logic [2:0]  resp_ack,
  input  logic [31:0] resp_rdata,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  output logic        wr_perr,
  output logic        line_reset,
  output logic        proto_err
);

  localparam int unsigned     LR_W   = $clog2(LINE_RESET_BITS + 1);
  localparam logic [LR_W-1:0] LR_MAX = LR_W'(LINE_RESET_BITS);
  localparam logic [2:0]      ACK_OK = 3'b001;

  typedef enum logic [3:0] {
    S_LOCKOUT,
    S_LRESET,
    S_IDLE,
    S_REQ,
    S_TRN1,
    S_ACK,
    S_RDATA,
    S_TRN2,
    S_WDATA
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] swclk_sync_q, swclk_sync_d;
  logic [SYNC_STAGES-1:0] swdio_sync_q, swdio_sync_d;
  logic                   swclk_prev_q, swclk_prev_d;
  logic                   swclk_s, swdio_s, edge_e;

  logic [LR_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [5:0]      req_sr_q, req_sr_d;
  logic [6:0]      req_bits;
  logic [2:0]      ack_q, ack_d;
  logic [31:0]     rdata_sr_q, rdata_sr_d;
  logic            rpar_q, rpar_d;
  logic [31:0]     wr_sr_q, wr_sr_d;
  logic            lr_hit;

  logic        swdio_o_q, swdio_o_d;
  logic        swdio_t_q, swdio_t_d;
  logic        req_valid_q, req_valid_d;
  logic        req_apndp_q, req_apndp_d;
  logic        req_rnw_q, req_rnw_d;
  logic [1:0]  req_addr_q, req_addr_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_perr_q, wr_perr_d;
  logic        line_reset_q, line_reset_d;
  logic        proto_err_q, proto_err_d;

  // Synchronizer chains for the asynchronous probe inputs
  always_comb begin
    swclk_sync_d    = '0;
    swdio_sync_d    = '0;
    swclk_sync_d[0] = swclk_i;
    swdio_sync_d[0] = swdio_i;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      swclk_sync_d[i] = swclk_sync_q[i-1];
      swdio_sync_d[i] = swdio_sync_q[i-1];
    end
  end

  assign swclk_s      = swclk_sync_q[SYNC_STAGES-1];
  assign swdio_s      = swdio_sync_q[SYNC_STAGES-1];
  assign swclk_prev_d = swclk_s;
  assign edge_e       = swclk_s & ~swclk_prev_q;

  // Next-state, line-reset detection and registered outputs, all evaluated on E
  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    req_sr_d     = req_sr_q;
    ack_d        = ack_q;
    rdata_sr_d   = rdata_sr_q;
    rpar_d       = rpar_q;
    wr_sr_d      = wr_sr_q;
    swdio_o_d    = swdio_o_q;
    swdio_t_d    = swdio_t_q;
    req_valid_d  = 1'b0;
    req_apndp_d  = req_apndp_q;
    req_rnw_d    = req_rnw_q;
    req_addr_d   = req_addr_q;
    wr_valid_d   = 1'b0;
    wr_data_d    = wr_data_q;
    wr_perr_d    = wr_perr_q;
    line_reset_d = 1'b0;
    proto_err_d  = 1'b0;
    lr_hit       = 1'b0;
    // {Park, Stop, Parity, A3, A2, RnW, APnDP} once the last request bit arrives
    req_bits     = {swdio_s, req_sr_q};

    if (edge_e) begin
      unique case (state_q)
        S_LOCKOUT: begin
        end
        S_LRESET: begin
          if (!swdio_s) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (swdio_s) begin
            state_d   = S_REQ;
            bit_cnt_d = '0;
          end
        end
        S_REQ: begin
          if (bit_cnt_q == 6'd6) begin
            if (!(^req_bits[4:0]) && !req_bits[5] && req_bits[6]) begin
              req_valid_d = 1'b1;
              req_apndp_d = req_bits[0];
              req_rnw_d   = req_bits[1];
              req_addr_d  = {req_bits[3], req_bits[2]};
              state_d     = S_TRN1;
            end else begin
              proto_err_d = 1'b1;
              state_d     = S_LOCKOUT;
            end
          end else begin
            req_sr_d  = {swdio_s, req_sr_q[5:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        S_TRN1: begin
          state_d   = S_ACK;
          bit_cnt_d = '0;
        end
        S_ACK: begin
          // ACK[0] goes out on the same edge that latches the response inputs
          if (bit_cnt_q == 6'd0) begin
            ack_d      = resp_ack;
            rdata_sr_d = resp_rdata;
            rpar_d     = ^resp_rdata;
            swdio_t_d  = 1'b0;
            swdio_o_d  = resp_ack[0];
            bit_cnt_d  = 6'd1;
          end else if (bit_cnt_q == 6'd1) begin
            swdio_o_d = ack_q[1];
            bit_cnt_d = 6'd2;
          end else begin
            swdio_o_d = ack_q[2];
            bit_cnt_d = '0;
            if (ack_q == ACK_OK && req_rnw_q) state_d = S_RDATA;
            else                              state_d = S_TRN2;
          end
        end
        S_RDATA: begin
          if (bit_cnt_q == 6'd32) begin
            swdio_o_d = rpar_q;
            state_d   = S_TRN2;
          end else begin
            swdio_o_d  = rdata_sr_q[0];
            rdata_sr_d = {1'b0, rdata_sr_q[31:1]};
            bit_cnt_d  = bit_cnt_q + 6'd1;
          end
        end
        S_TRN2: begin
          swdio_t_d = 1'b1;
          swdio_o_d = 1'b0;
          bit_cnt_d = '0;
          if (ack_q == ACK_OK && !req_rnw_q) state_d = S_WDATA;
          else                               state_d = S_IDLE;
        end
        S_WDATA: begin
          if (bit_cnt_q == 6'd32) begin
            wr_valid_d = 1'b1;
            wr_data_d  = wr_sr_q;
            wr_perr_d  = ^{wr_sr_q, swdio_s};
            state_d    = S_IDLE;
          end else begin
            wr_sr_d   = {swdio_s, wr_sr_q[31:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        default: state_d = S_LOCKOUT;
      endcase

      // High-run counter only observes the line while the target is not driving
      if (swdio_t_q) begin
        if (!swdio_s) begin
          hi_cnt_d = '0;
        end else if (hi_cnt_q != LR_MAX) begin
          hi_cnt_d = hi_cnt_q + LR_W'(1);
          if (hi_cnt_q == LR_MAX - LR_W'(1)) lr_hit = 1'b1;
        end
      end else begin
        hi_cnt_d = '0;
      end

      // Line reset overrides whatever the state decode chose on this edge
      if (lr_hit) begin
        state_d      = S_LRESET;
        line_reset_d = 1'b1;
        swdio_t_d    = 1'b1;
        swdio_o_d    = 1'b0;
        req_valid_d  = 1'b0;
        req_apndp_d  = req_apndp_q;
        req_rnw_d    = req_rnw_q;
        req_addr_d   = req_addr_q;
        proto_err_d  = 1'b0;
        wr_valid_d   = 1'b0;
        wr_data_d    = wr_data_q;
        wr_perr_d    = wr_perr_q;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOCKOUT;
      swclk_sync_q <= '0;
      swdio_sync_q <= '0;
      swclk_prev_q <= 1'b0;
      hi_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      req_sr_q     <= '0;
      ack_q        <= '0;
      rdata_sr_q   <= '0;
      rpar_q       <= 1'b0;
      wr_sr_q      <= '0;
      swdio_o_q    <= 1'b0;
      swdio_t_q    <= 1'b1;
      req_valid_q  <= 1'b0;
      req_apndp_q  <= 1'b0;
      req_rnw_q    <= 1'b0;
      req_addr_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
      wr_perr_q    <= 1'b0;
      line_reset_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      swclk_sync_q <= swclk_sync_d;
      swdio_sync_q <= swdio_sync_d;
      swclk_prev_q <= swclk_prev_d;
      hi_cnt_q     <= hi_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      req_sr_q     <= req_sr_d;
      ack_q        <= ack_d;
      rdata_sr_q   <= rdata_sr_d;
      rpar_q       <= rpar_d;
      wr_sr_q      <= wr_sr_d;
      swdio_o_q    <= swdio_o_d;
      swdio_t_q    <= swdio_t_d;
      req_valid_q  <= req_valid_d;
      req_apndp_q  <= req_apndp_d;
      req_rnw_q    <= req_rnw_d;
      req_addr_q   <= req_addr_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      wr_perr_q    <= wr_perr_d;
      line_reset_q <= line_reset_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign swdio_o    = swdio_o_q;
  assign swdio_t    = swdio_t_q;
  assign req_valid  = req_valid_q;
  assign req_apndp  = req_apndp_q;
  assign req_rnw    = req_rnw_q;
  assign req_addr   = req_addr_q;
  assign wr_valid   = wr_valid_q;
  assign wr_data    = wr_data_q;
  assign wr_perr    = wr_perr_q;
  assign line_reset = line_reset_q;
  assign proto_err  = proto_err_q;

endmodule
